// File: rtl/lfsr_tpg_pkg.sv
// Shared BIST definitions: TPG/MISR state encoding, polynomial taps, session defaults
// and the mapping of an LFSR word onto the adder CUT operands.
package lfsr_tpg_pkg;

    localparam int TPG_BIT_DEF = 33;
    localparam int TAP_HI      = 33;
    localparam int TAP_LO      = 20;
    localparam int NUM_PAT_DEF = 127;
    localparam int WARMUP_DEF  = 33;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } tpg_state_t;

    // Field order mirrors the LFSR bit order: cin is the MSB, a the low half.
    typedef struct packed {
        logic        cin;
        logic [15:0] b;
        logic [15:0] a;
    } cut_pat_t;

    function automatic cut_pat_t to_pat(input logic [TPG_BIT_DEF-1:0] v);
        return cut_pat_t'(v);
    endfunction

endpackage

// File: rtl/lfsr_shift.sv
// One step of a Fibonacci LFSR with a two-tap feedback polynomial x^TAP_HI + x^TAP_LO + 1.
module lfsr_shift #(
    parameter int WIDTH  = 33,
    parameter int TAP_HI = 33,
    parameter int TAP_LO = 20
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = {din[WIDTH-2:0], din[TAP_HI-1] ^ din[TAP_LO-1]};

endmodule

// File: rtl/lfsr_tpg.sv
// BIST test pattern generator: seeds an LFSR, warms it up, then streams NUM_PAT
// patterns to the adder CUT with stall (hold) and abort support.
module lfsr_tpg
    import lfsr_tpg_pkg::*;
#(
    parameter int TPG_BIT = TPG_BIT_DEF,
    parameter int NUM_PAT = NUM_PAT_DEF,
    parameter int WARMUP  = WARMUP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TPG_BIT-1:0] seed,
    input  logic               hold,
    input  logic               abort,
    output logic               pat_valid,
    output logic [15:0]        a,
    output logic [15:0]        b,
    output logic               cin,
    output logic               busy,
    output logic               done
);

    localparam logic [5:0] WARM_LAST = 6'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [7:0] PAT_LAST  = 8'(NUM_PAT);

    tpg_state_t         state_q, state_n;
    logic [TPG_BIT-1:0] lfsr_q, lfsr_n, lfsr_sh, seed_fix;
    logic [5:0]         wcnt_q, wcnt_n;
    logic [7:0]         pcnt_q, pcnt_n;
    cut_pat_t           pat_q, pat_n;
    logic               pv_q, pv_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;

    lfsr_shift #(
        .WIDTH  (TPG_BIT),
        .TAP_HI (TAP_HI),
        .TAP_LO (TAP_LO)
    ) u_shift (
        .din  (lfsr_q),
        .dout (lfsr_sh)
    );

    assign seed_fix = (seed == '0) ? TPG_BIT'(1) : seed;

    // lfsr_q holds the pattern currently on a/b/cin while in RUN; a shift both
    // advances the LFSR and loads the output register with the new word, so a
    // hold sampled on one edge blanks pat_valid for the following cycle.
    always_comb begin
        state_n = state_q;
        lfsr_n  = lfsr_q;
        wcnt_n  = wcnt_q;
        pcnt_n  = pcnt_q;
        pat_n   = pat_q;
        pv_n    = 1'b0;
        busy_n  = busy_q;
        done_n  = done_q;
        if (abort) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lfsr_n = seed_fix;
                        wcnt_n = '0;
                        pcnt_n = '0;
                        busy_n = 1'b1;
                        done_n = 1'b0;
                        if (WARMUP == 0) begin
                            state_n = ST_RUN;
                            pat_n   = to_pat(seed_fix);
                            pv_n    = 1'b1;
                            pcnt_n  = 8'd1;
                        end else begin
                            state_n = ST_WARMUP;
                        end
                    end
                end
                ST_WARMUP: begin
                    lfsr_n = lfsr_sh;
                    wcnt_n = wcnt_q + 6'd1;
                    if (wcnt_q == WARM_LAST) begin
                        state_n = ST_RUN;
                        pat_n   = to_pat(lfsr_sh);
                        pv_n    = 1'b1;
                        pcnt_n  = 8'd1;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        if (pcnt_q == PAT_LAST) begin
                            state_n = ST_DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            lfsr_n = lfsr_sh;
                            pat_n  = to_pat(lfsr_sh);
                            pv_n   = 1'b1;
                            pcnt_n = pcnt_q + 8'd1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= TPG_BIT'(1);
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            pat_q   <= '0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            lfsr_q  <= lfsr_n;
            wcnt_q  <= wcnt_n;
            pcnt_q  <= pcnt_n;
            pat_q   <= pat_n;
            pv_q    <= pv_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign pat_valid = pv_q;
    assign a         = pat_q.a;
    assign b         = pat_q.b;
    assign cin       = pat_q.cin;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Bench for lfsr_tpg: three instances (small session, defaults, zero warm-up)
// checked cycle by cycle against a pattern/timing reference model.
module tb_lfsr_tpg;

    localparam int MAXC = 1024;
    localparam int WP[3] = '{4, 33, 0};
    localparam int NP[3] = '{3, 127, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, hold, abort;
    logic [32:0] seed;
    int          sel;
    logic        start_s, start_d, start_z;
    logic        pv_s, pv_d, pv_z, cin_s, cin_d, cin_z;
    logic        busy_s, busy_d, busy_z, done_s, done_d, done_z;
    logic [15:0] a_s, a_d, a_z, b_s, b_d, b_z;
    logic        o_pv, o_busy, o_done;
    logic [32:0] o_pat;

    assign start_s = start && (sel == 0);
    assign start_d = start && (sel == 1);
    assign start_z = start && (sel == 2);

    lfsr_tpg #(.TPG_BIT(33), .NUM_PAT(3), .WARMUP(4)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .seed(seed), .hold(hold), .abort(abort),
        .pat_valid(pv_s), .a(a_s), .b(b_s), .cin(cin_s), .busy(busy_s), .done(done_s));
    lfsr_tpg dut_d (
        .clk(clk), .reset(reset), .start(start_d), .seed(seed), .hold(hold), .abort(abort),
        .pat_valid(pv_d), .a(a_d), .b(b_d), .cin(cin_d), .busy(busy_d), .done(done_d));
    lfsr_tpg #(.TPG_BIT(33), .NUM_PAT(1), .WARMUP(0)) dut_z (
        .clk(clk), .reset(reset), .start(start_z), .seed(seed), .hold(hold), .abort(abort),
        .pat_valid(pv_z), .a(a_z), .b(b_z), .cin(cin_z), .busy(busy_z), .done(done_z));

    always_comb begin
        o_pv = pv_s; o_pat = {cin_s, b_s, a_s}; o_busy = busy_s; o_done = done_s;
        if (sel == 1) begin
            o_pv = pv_d; o_pat = {cin_d, b_d, a_d}; o_busy = busy_d; o_done = done_d;
        end else if (sel == 2) begin
            o_pv = pv_z; o_pat = {cin_z, b_z, a_z}; o_busy = busy_z; o_done = done_z;
        end
    end

    int tests = 0;
    int fails = 0;

    bit          h_vec[MAXC], st_vec[MAXC], ab_vec[MAXC], rs_vec[MAXC];
    bit          obs_pv[MAXC], obs_busy[MAXC], obs_done[MAXC];
    logic [32:0] obs_pat[MAXC];
    bit          exp_pv[MAXC];
    logic [32:0] exp_pat[MAXC];
    int          exp_first, exp_done;

    // x^33 + x^20 + 1: feedback is the XOR of the bits at degrees 33 and 20.
    function automatic logic [32:0] step(input logic [32:0] s);
        logic fb;
        fb = s[33-1] ^ s[20-1];
        return {s[31:0], fb};
    endfunction

    task automatic clear_vec();
        for (int j = 0; j < MAXC; j++) begin
            h_vec[j] = 0; st_vec[j] = 0; ab_vec[j] = 0; rs_vec[j] = 0;
        end
    endtask

    task automatic rand_holds(input int pct);
        for (int j = 1; j < MAXC; j++) h_vec[j] = ($urandom_range(99) < pct);
    endtask

    // Cycle j is relative to the start cycle (j=0); pattern k is the seed advanced
    // WARMUP+k steps, and each held RUN cycle pushes all later events out by one.
    task automatic build_model(input int w, input int n, input logic [32:0] sd);
        logic [32:0] p;
        int c;
        p = (sd == 33'h0) ? 33'h1 : sd;
        for (int i = 0; i < w; i++) p = step(p);
        for (int j = 0; j < MAXC; j++) begin exp_pv[j] = 0; exp_pat[j] = 'x; end
        c = 1 + w;
        exp_first = c;
        for (int k = 0; k < n; k++) begin
            exp_pv[c] = 1; exp_pat[c] = p;
            while (h_vec[c]) begin c++; exp_pat[c] = p; end
            c++;
            if (k < n - 1) p = step(p);
        end
        exp_done = c;
        for (int j = c; j < MAXC; j++) exp_pat[j] = p;
    endtask

    task automatic capture(input int len);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            obs_pv[j] = o_pv; obs_pat[j] = o_pat; obs_busy[j] = o_busy; obs_done[j] = o_done;
            reset = rs_vec[j]; start = st_vec[j]; hold = h_vec[j]; abort = ab_vec[j];
        end
        reset = 0; start = 0; hold = 0; abort = 0;
    endtask

    task automatic test_session(input string name, input int s, input logic [32:0] sd,
                                input bit rand_start);
        int len, npv;
        sel = s; seed = sd;
        build_model(WP[s], NP[s], sd);
        st_vec[0] = 1;
        if (rand_start) for (int j = 1; j < exp_done; j++) st_vec[j] = ($urandom_range(5) == 0);
        len = exp_done + 3;
        capture(len);
        npv = 0;
        for (int j = 1; j < len; j++) begin
            npv += int'(obs_pv[j]);
            tests++;
            if (obs_pv[j] !== exp_pv[j]) begin
                fails++; $display("FAIL %s pat_valid cyc %0d: got %0b want %0b", name, j, obs_pv[j], exp_pv[j]);
            end
            if (j >= exp_first) begin
                tests++;
                if (obs_pat[j] !== exp_pat[j]) begin
                    fails++; $display("FAIL %s pattern cyc %0d: got %09h want %09h", name, j, obs_pat[j], exp_pat[j]);
                end
            end
            tests++;
            if (obs_busy[j] !== (j < exp_done) || obs_done[j] !== (j >= exp_done)) begin
                fails++; $display("FAIL %s busy/done cyc %0d: got %0b/%0b want %0b/%0b", name, j,
                                  obs_busy[j], obs_done[j], j < exp_done, j >= exp_done);
            end
            if (obs_pv[j] && obs_pat[j] == 33'h0) begin
                tests++; fails++; $display("FAIL %s zero_lfsr cyc %0d: got 0 want nonzero", name, j);
            end
        end
        tests++;
        if (npv != NP[s]) begin
            fails++; $display("FAIL %s pat_count: got %0d want %0d", name, npv, NP[s]);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({pv_s, a_s, b_s, cin_s, busy_s, done_s} !== 35'h0) begin
            fails++; $display("FAIL reset_s: got %09h want 0", {pv_s, a_s, b_s, cin_s, busy_s, done_s});
        end
        tests++;
        if ({pv_d, a_d, b_d, cin_d, busy_d, done_d} !== 35'h0) begin
            fails++; $display("FAIL reset_d: got %09h want 0", {pv_d, a_d, b_d, cin_d, busy_d, done_d});
        end
        tests++;
        if ({pv_z, a_z, b_z, cin_z, busy_z, done_z} !== 35'h0) begin
            fails++; $display("FAIL reset_z: got %09h want 0", {pv_z, a_z, b_z, cin_z, busy_z, done_z});
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_basic(input string name, input logic [32:0] sd);
        logic [32:0] want[3];
        want[0] = 33'h10; want[1] = 33'h20; want[2] = 33'h40;
        clear_vec();
        test_session(name, 0, sd, 0);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs_pv[5+k] !== 1'b1 || obs_pat[5+k] !== want[k]) begin
                fails++; $display("FAIL %s fixed_pat%0d: got %0b/%09h want 1/%09h", name, k, obs_pv[5+k], obs_pat[5+k], want[k]);
            end
        end
        tests++;
        if (obs_pv[4] !== 1'b0 || obs_done[7] !== 1'b0 || obs_done[8] !== 1'b1) begin
            fails++; $display("FAIL %s latency: got pv4=%0b done7=%0b done8=%0b want 0/0/1", name, obs_pv[4], obs_done[7], obs_done[8]);
        end
    endtask

    task automatic test_hold();
        clear_vec();
        h_vec[6] = 1; h_vec[7] = 1;
        test_session("hold", 0, 33'h1, 0);
        tests++;
        if ({obs_pv[7], obs_pv[8], obs_pv[9]} !== 3'b001 || obs_pat[7] !== 33'h20 ||
            obs_pat[8] !== 33'h20 || obs_pat[9] !== 33'h40) begin
            fails++; $display("FAIL hold_freeze: got pv=%0b%0b%0b a=%09h,%09h,%09h want 001 20,20,40",
                              obs_pv[7], obs_pv[8], obs_pv[9], obs_pat[7], obs_pat[8], obs_pat[9]);
        end
        tests++;
        if (obs_done[9] !== 1'b0 || obs_done[10] !== 1'b1) begin
            fails++; $display("FAIL hold_done_delay: got done9=%0b done10=%0b want 0/1", obs_done[9], obs_done[10]);
        end
    endtask

    task automatic test_abort();
        logic [32:0] sd;
        sd = {$urandom_range(1), $urandom()} | 33'h1;
        clear_vec();
        sel = 0; seed = sd;
        build_model(WP[0], NP[0], sd);
        st_vec[0] = 1; ab_vec[6] = 1; st_vec[6] = 1;
        capture(20);
        tests++;
        if (obs_pv[5] !== 1'b1 || obs_pat[5] !== exp_pat[5]) begin
            fails++; $display("FAIL abort_first_pat: got %0b/%09h want 1/%09h", obs_pv[5], obs_pat[5], exp_pat[5]);
        end
        for (int j = 7; j < 20; j++) begin
            tests++;
            if (obs_pv[j] !== 1'b0 || obs_busy[j] !== 1'b0 || obs_done[j] !== 1'b0) begin
                fails++; $display("FAIL abort_idle cyc %0d: got pv/busy/done=%0b%0b%0b want 000", j, obs_pv[j], obs_busy[j], obs_done[j]);
            end
        end
        clear_vec();
        test_session("abort_restart", 0, ~sd, 0);
    endtask

    task automatic test_warmup0();
        logic [32:0] sd;
        sd = {1'b0, $urandom()} | 33'h100;
        clear_vec();
        test_session("warmup0", 2, sd, 0);
        tests++;
        if (obs_pv[1] !== 1'b1 || obs_pat[1] !== sd || obs_done[2] !== 1'b1) begin
            fails++; $display("FAIL warmup0_direct: got pv=%0b pat=%09h done=%0b want 1/%09h/1", obs_pv[1], obs_pat[1], obs_done[2], sd);
        end
    endtask

    task automatic test_reset_mid();
        clear_vec();
        sel = 0; seed = 33'h5A5A5;
        st_vec[0] = 1; rs_vec[2] = 1; st_vec[2] = 1; ab_vec[2] = 1;
        capture(10);
        tests++;
        if (obs_pv[3] !== 1'b0 || obs_pat[3] !== 33'h0 || obs_busy[3] !== 1'b0 || obs_done[3] !== 1'b0) begin
            fails++; $display("FAIL reset_mid: got pv=%0b pat=%09h busy=%0b done=%0b want 0/0/0/0", obs_pv[3], obs_pat[3], obs_busy[3], obs_done[3]);
        end
        for (int j = 4; j < 10; j++) begin
            tests++;
            if (obs_pv[j] !== 1'b0 || obs_busy[j] !== 1'b0) begin
                fails++; $display("FAIL reset_mid_idle cyc %0d: got pv/busy=%0b%0b want 00", j, obs_pv[j], obs_busy[j]);
            end
        end
    endtask

    initial begin
        reset = 1; start = 0; hold = 0; abort = 0; seed = '0; sel = 0;
        test_reset();
        test_basic("basic", 33'h1);
        test_basic("zero_seed", 33'h0);
        test_hold();
        test_abort();
        test_warmup0();
        clear_vec();
        test_session("defaults", 1, 33'h1ABCDEF01, 0);
        for (int r = 0; r < 2; r++) begin
            clear_vec(); rand_holds(25);
            test_session("defaults_rand", 1, {$urandom_range(1), $urandom()}, 1);
        end
        for (int r = 0; r < 6; r++) begin
            clear_vec(); rand_holds(30);
            test_session("small_rand", 0, {$urandom_range(1), $urandom()}, 1);
        end
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
